// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control unit: state encodings,
// button indices, the per-cycle button event bundle and default timing.
package stopwatch_pkg;

    localparam int STATE_W         = 2;
    localparam int DEF_CLK_HZ      = 100_000_000;
    localparam int DEF_DEBOUNCE_MS = 10;

    // Index of each button inside the packed button vectors.
    localparam int BTN_RUN = 0;
    localparam int BTN_CLR = 1;
    localparam int BTN_LAP = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } state_t;

    // One-cycle accepted-press events feeding the FSM.
    typedef struct packed {
        logic run_stop;
        logic clear;
        logic lap;
    } btn_evt_t;

    // Stable cycles needed before a new button level is accepted.
    function automatic int db_cycles(input int clk_hz, input int debounce_ms);
        return clk_hz / 1000 * debounce_ms;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button path: 2-FF synchroniser, stability counter, rising-edge pulse.
// A press that is already held when reset releases is not reported; the
// path only arms once it has seen the button released after reset.
module btn_debounce #(
    parameter int DB_COUNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_pulse
);

    localparam int CNT_W = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

    logic [1:0]       sync;
    logic             synced;
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             level_d1;
    logic [1:0]       vld_pipe;
    logic             armed;

    assign synced = sync[1];

    // Two-stage synchroniser for the asynchronous raw button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[0], i_btn};
    end

    // Accept the synced level only after it differed from the debounced level for DB_COUNT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (synced == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= synced;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Delayed level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) level_d1 <= 1'b0;
        else        level_d1 <= level;
    end

    // Arm once the synchroniser holds a real sample and the button is seen released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            armed    <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[0], 1'b1};
            if (vld_pipe[1] && !synced && !level) armed <= 1'b1;
        end
    end

    assign o_level = level;
    assign o_pulse = level & ~level_d1 & armed;

endmodule

// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: debounced buttons drive a STOP/RUN/CLEAR FSM whose
// decoded state feeds the datapath run_stop/clear inputs.
// Optional macro STOPWATCH_LAP_EN adds a lap button path and lap-hold flag;
// without it btn_lap is ignored and o_lap_hold is tied low.
module stopwatch_cu
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ      = DEF_CLK_HZ,
    parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_run_stop,
    input  logic               btn_clear,
    input  logic               btn_lap,
    output logic               o_run_stop,
    output logic               o_clear,
    output logic               o_lap_hold,
    output logic [STATE_W-1:0] o_state
);

    localparam int DB_COUNT = db_cycles(CLK_HZ, DEBOUNCE_MS);
`ifdef STOPWATCH_LAP_EN
    localparam int NUM_BTN = 3;
`else
    localparam int NUM_BTN = 2;
`endif

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_pulse;
    logic [NUM_BTN-1:0] level_unused;
    btn_evt_t           evt;
    state_t             state;
    state_t             state_nxt;

    assign btn_raw[BTN_RUN] = btn_run_stop;
    assign btn_raw[BTN_CLR] = btn_clear;
`ifdef STOPWATCH_LAP_EN
    assign btn_raw[BTN_LAP] = btn_lap;
`else
    logic lap_unused;
    assign lap_unused = btn_lap;
`endif

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        btn_debounce #(.DB_COUNT(DB_COUNT)) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_btn   (btn_raw[gi]),
            .o_level (level_unused[gi]),
            .o_pulse (btn_pulse[gi])
        );
    end

    assign evt.run_stop = btn_pulse[BTN_RUN];
    assign evt.clear    = btn_pulse[BTN_CLR];
`ifdef STOPWATCH_LAP_EN
    assign evt.lap      = btn_pulse[BTN_LAP];
`else
    assign evt.lap      = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_STOP;
        else        state <= state_nxt;
    end

    // Next-state: clear beats run/stop in STOP, clear is ignored in RUN, CLEAR lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_STOP: begin
                if (evt.clear)         state_nxt = ST_CLEAR;
                else if (evt.run_stop) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (evt.run_stop) state_nxt = ST_STOP;
            end
            ST_CLEAR: state_nxt = ST_STOP;
            default:  state_nxt = ST_STOP;
        endcase
    end

`ifdef STOPWATCH_LAP_EN
    logic lap_hold;
    logic lap_nxt;

    // Lap flag toggles only while staying in RUN; any other case clears it.
    always_comb begin
        lap_nxt = 1'b0;
        if (state == ST_RUN && state_nxt == ST_RUN) lap_nxt = lap_hold ^ evt.lap;
    end

    // Lap-hold register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lap_hold <= 1'b0;
        else        lap_hold <= lap_nxt;
    end

    assign o_lap_hold = lap_hold;
`else
    assign o_lap_hold = 1'b0;
`endif

    assign o_run_stop = (state == ST_RUN);
    assign o_clear    = (state == ST_CLEAR);
    assign o_state    = state;

endmodule
